// File: rtl/skid_pkg.sv
// Shared defaults and elaboration helpers for the skid_fifo elastic buffer.
package skid_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 4;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/skid_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module skid_mem
  import skid_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/skid_fifo.sv
// DEPTH-entry registered elastic buffer on a valid/ready stream with flush and occupancy.
// All handshake outputs are decoded from flops only; nothing combinational crosses the buffer.
module skid_fifo
  import skid_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned CW    = count_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid_i,
  input  logic [DATA_W-1:0] i_data_i,
  output logic              i_ready_o,
  input  logic              e_ready_i,
  output logic              e_valid_o,
  output logic [DATA_W-1:0] e_data_o,
  input  logic              flush_i,
  output logic [CW-1:0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("skid_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rdy_q, rdy_d;
  logic          push_c, pop_c, we_c;

  // Next-state: flush wins over any concurrent push/pop.
  always_comb begin
    push_c   = i_valid_i & rdy_q;
    pop_c    = (count_q != '0) & e_ready_i;
    we_c     = push_c & ~flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    // Ready looks ahead at the next occupancy so it can be a plain flop.
    rdy_d = (count_d < CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
    end
  end

  skid_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (we_c),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (e_data_o)
  );

  assign i_ready_o = rdy_q;
  assign e_valid_o = (count_q != '0);
  assign count_o   = count_q;

endmodule

// File: tb/tb_skid_fifo.sv
// Self-checking bench for skid_fifo: a negedge monitor keeps a scoreboard queue of
// accepted words and checks occupancy, handshakes and output order every cycle.
module tb_skid_fifo;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              i_valid_i;
  logic [DATA_W-1:0] i_data_i;
  logic              i_ready_o;
  logic              e_ready_i;
  logic              e_valid_o;
  logic [DATA_W-1:0] e_data_o;
  logic              flush_i;
  logic [CW-1:0]     count_o;

  int                n_chk   = 0;
  int                n_fail  = 0;
  int                pop_cnt = 0;
  bit                mon_en  = 1'b0;
  bit                rdy_exp = 1'b0;
  logic [DATA_W-1:0] sb_q [$];

  always #5 clk = ~clk;

  skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid_i (i_valid_i),
    .i_data_i  (i_data_i),
    .i_ready_o (i_ready_o),
    .e_ready_i (e_ready_i),
    .e_valid_o (e_valid_o),
    .e_data_o  (e_data_o),
    .flush_i   (flush_i),
    .count_o   (count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: check state left by the last edge, then apply what the coming edge will do.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", 32'(count_o), 32'(sb_q.size()));
      check("e_valid", 32'(e_valid_o), 32'(sb_q.size() != 0));
      check("i_ready", 32'(i_ready_o), 32'(rdy_exp));
      if (reset) begin
        sb_q.delete();
        rdy_exp = 1'b0;
      end else if (flush_i) begin
        sb_q.delete();
        rdy_exp = 1'b1;
      end else begin
        if ((sb_q.size() != 0) && e_ready_i) begin
          check("e_data", 32'(e_data_o), 32'(sb_q.pop_front()));
          pop_cnt++;
        end
        if (i_valid_i && rdy_exp) sb_q.push_back(i_data_i);
        rdy_exp = (sb_q.size() < int'(DEPTH));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    i_valid_i = 1'b1;
    i_data_i  = d;
    step();
    i_valid_i = 1'b0;
  endtask

  initial begin
    int pc0;
    reset     = 1'b1;
    i_valid_i = 1'b0;
    i_data_i  = '0;
    e_ready_i = 1'b0;
    flush_i   = 1'b0;

    // Reset and idle; ready rises one edge after reset drops.
    step();
    step();
    mon_en = 1'b1;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_e_valid", 32'(e_valid_o), 32'd0);
    check("rst_e_data", 32'(e_data_o), 32'd0);
    check("rst_i_ready", 32'(i_ready_o), 32'd0);
    reset = 1'b0;
    #2;
    check("rdy_before_edge", 32'(i_ready_o), 32'd0);
    step();
    check("rdy_after_edge", 32'(i_ready_o), 32'd1);
    step();

    // Fill to FULL; a fifth push is ignored.
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    check("full_count", 32'(count_o), 32'd4);
    check("full_ready", 32'(i_ready_o), 32'd0);
    push_word(8'h55);
    check("ignored_push", 32'(count_o), 32'd4);

    // One pop from FULL, then ready returns; drain in order.
    e_ready_i = 1'b1;
    step();
    e_ready_i = 1'b0;
    check("pop1_count", 32'(count_o), 32'd3);
    check("pop1_ready", 32'(i_ready_o), 32'd1);
    e_ready_i = 1'b1;
    repeat (3) step();
    check("drained_count", 32'(count_o), 32'd0);
    check("drained_pops", 32'(pop_cnt), 32'd4);

    // Streaming 64 words with both sides active: no bubbles after the first.
    pc0 = pop_cnt;
    for (int i = 0; i < 64; i++) begin
      i_valid_i = 1'b1;
      i_data_i  = DATA_W'(i);
      step();
      if (i > 0) check("stream_count", 32'(count_o), 32'd1);
    end
    i_valid_i = 1'b0;
    step();
    check("stream_pops", 32'(pop_cnt - pc0), 32'd64);
    check("stream_empty", 32'(count_o), 32'd0);

    // Flush with a concurrent push: nothing survives.
    e_ready_i = 1'b0;
    push_word(8'hA0);
    push_word(8'hA1);
    push_word(8'hA2);
    check("pre_flush_count", 32'(count_o), 32'd3);
    flush_i   = 1'b1;
    i_valid_i = 1'b1;
    i_data_i  = 8'hAA;
    step();
    flush_i   = 1'b0;
    i_valid_i = 1'b0;
    check("flush_count", 32'(count_o), 32'd0);
    check("flush_e_valid", 32'(e_valid_o), 32'd0);
    check("flush_ready", 32'(i_ready_o), 32'd1);
    push_word(8'h5A);
    check("post_flush_head", 32'(e_data_o), 32'h5A);
    e_ready_i = 1'b1;
    step();
    check("post_flush_empty", 32'(count_o), 32'd0);

    // Reset mid-stream while draining.
    e_ready_i = 1'b0;
    push_word(8'hC1);
    push_word(8'hC2);
    check("pre_rst_count", 32'(count_o), 32'd2);
    e_ready_i = 1'b1;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_count", 32'(count_o), 32'd0);
    check("midrst_e_valid", 32'(e_valid_o), 32'd0);
    check("midrst_ready", 32'(i_ready_o), 32'd0);
    repeat (4) begin
      step();
      check("no_stale", 32'(e_valid_o), 32'd0);
    end

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/skid_fifo.md
# skid_fifo

Parametrised successor to the single-entry skid buffer: a DEPTH-entry elastic buffer on a valid/ready stream of DATA_W-bit words. It sits between a producer and a consumer to break timing on every handshake path. i_ready_o, e_valid_o and e_data_o are decoded from flops only, with no combinational path from input to output. It adds a synchronous flush and an occupancy output for upstream credit/monitoring logic.

## Interface
- DATA_W, 8: payload width in bits, ≥1.
- DEPTH, 4: number of storage entries; power of two, ≥2.
- CW, $clog2(DEPTH+1): width of count_o. Derived; not overridden.
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- i_valid_i  in  1  upstream word valid.
- i_data_i  in  DATA_W  upstream word.
- i_ready_o  out  1  buffer can accept; registered.
- e_ready_i  in  1  downstream can accept.
- e_valid_o  out  1  head word valid.
- e_data_o  out  DATA_W  head word.
- flush_i  in  1  discard all stored words this edge.
- count_o  out  CW  number of stored words, 0..DEPTH.

## Operation
- push = i_valid_i & i_ready_o. pop = e_valid_o & e_ready_i. Words are delivered in order; none are dropped or duplicated.
- Storage is a register array `mem[DEPTH]` with wr_ptr and rd_ptr, each $clog2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0.
- count_q is updated as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together, or on neither.
- i_ready_o = rdy_q, where rdy_q <= (count_next < DEPTH). It is therefore high in the cycle after a pop frees the last slot, never in the same cycle. There is no combinational path from e_ready_i to i_ready_o.
- e_valid_o = (count_q != 0). e_data_o = mem[rd_ptr]. Both are flop-driven; there is no path from i_* to e_*.
- Occupancy classes:
  - EMPTY (count 0): e_valid_o=0, i_ready_o=1.
  - PARTIAL (1..DEPTH-1): both handshakes active; full throughput of one word per cycle.
  - FULL (DEPTH): i_ready_o=0. A pop returns the buffer to PARTIAL, and i_ready_o rises on the following edge.
- A push presented while i_ready_o=0 is ignored, and the data is not stored. Holding i_valid_i and i_data_i stable is the upstream's responsibility.
- flush_i has priority over push and pop. On a flush edge, count_q, wr_ptr and rd_ptr go to 0, rdy_q goes to 1, and a concurrent push or pop is discarded. mem contents are left unchanged.
- reset has priority over everything. count_q, the pointers and mem are cleared to 0, and rdy_q goes to 0.
- count_o = count_q.

## Timing
- Output values in the cycle after a reset edge: i_ready_o=0, e_valid_o=0, e_data_o=0, count_o=0.
- i_ready_o rises to 1 at the first edge with reset low.
- Reset asserted mid-stream empties the buffer at that edge. All in-flight words are lost, and no e_valid_o pulse follows.
- Latency: a word pushed at edge N appears on e_valid_o/e_data_o from edge N into cycle N+1, when the buffer was EMPTY. Otherwise it waits behind the words ahead of it.
- A pop and a push in the same cycle when count=DEPTH cannot occur, because i_ready_o=0.
- A pop and a push in the same cycle when count=0 cannot occur, because e_valid_o=0.
- Sustained throughput is 1 word/cycle with both sides continuously active.
- After FULL then one pop, there is exactly one bubble cycle on the input side.

## Structure
- Package skid_pkg:
  - default DATA_W and DEPTH constants;
  - count-width function (clog2(DEPTH+1));
  - elaboration check that DEPTH is a power of two and ≥2.
- One sub-module, skid_mem: DEPTH×DATA_W register array with one synchronous write port (we, waddr, wdata), one asynchronous read port, and synchronous reset to 0.
- Pointers, count, rdy_q and flush/reset priority live in skid_fifo.

## Test plan
- Reset, then idle → count_o=0, e_valid_o=0, e_data_o=0, and i_ready_o goes 0→1 one edge after reset drops.
- DEPTH=4, e_ready_i=0, push 0x11,0x22,0x33,0x44 on consecutive cycles → count_o reaches 4, i_ready_o=0, and a fifth push of 0x55 is ignored.
- From FULL, set e_ready_i=1 for one cycle → 0x11 is popped, count_o=3, and i_ready_o returns to 1 on the next edge. Draining yields 0x22,0x33,0x44 in order.
- Both sides continuously active for 64 words (0x00..0x3F) → output is identical and in order, count_o stays 1, and there are no bubbles after the first word.
- count_o=3, then flush_i and i_valid_i asserted together with 0xAA → count_o=0, e_valid_o=0 next cycle, and 0xAA is not stored.
- Reset asserted while count_o=2 and e_ready_i=1 → the next cycle shows count_o=0, e_valid_o=0 and i_ready_o=0, and no stale word appears afterward.
